// File: rtl/ss_pkg.sv
// Shared constants for the seven-segment scan driver: panel size, idle pin levels and hex glyphs.
package ss_pkg;
   localparam int NUM_DIGITS = 8;
   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   // Active-high {g,f,e,d,c,b,a}; all 16 codes so formatter status nibbles still render.
   localparam logic [6:0] HEX7 [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };
endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment glyph lookup.
module hex_to_seg7
   import ss_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);
   assign o_seg = HEX7[i_nibble];
endmodule

// File: rtl/ss_scan_driver.sv
// Time-multiplexes a frame-latched 8-nibble word onto a common-anode 7-seg panel
// with per-digit enable, blink and decimal point; one blank cycle per slot against ghosting.
module ss_scan_driver
   import ss_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 50000000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] display_in,
   input  logic [7:0]  digit_en,
   input  logic [7:0]  blink_en,
   input  logic [7:0]  dp_in,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_tick
);
   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   logic [SCAN_W-1:0]  r_scan_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic [BLINK_W-1:0] r_blink_cnt;
   logic               r_blink_phase;
   logic               r_load_pend;
   logic [31:0]        r_word_buf;
   logic [7:0]         r_en_buf;
   logic [7:0]         r_blink_buf;
   logic [7:0]         r_dp_buf;
   logic [7:0]         r_an;
   logic [6:0]         r_seg;
   logic               r_dp;
   logic               r_frame_tick;

   logic               w_scan_wrap;
   logic               w_blink_wrap;
   logic               w_load;
   logic               w_lit;
   logic               w_drive;
   logic [3:0]         w_nibbles [NUM_DIGITS];
   logic [3:0]         w_nibble;
   logic [6:0]         w_seg_hi;

   assign w_scan_wrap  = (r_scan_cnt == SCAN_LAST);
   assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);
   assign w_load       = r_load_pend | (w_scan_wrap & (r_idx == IDX_LAST));

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign w_nibbles[gi] = r_word_buf[4*gi +: 4];
   end
   assign w_nibble = w_nibbles[r_idx];

   hex_to_seg7 u_hex_to_seg7 (
      .i_nibble (w_nibble),
      .o_seg    (w_seg_hi)
   );

   // blink_phase=1 is the blanked half-period.
   assign w_lit   = r_en_buf[r_idx] & ~(r_blink_buf[r_idx] & r_blink_phase);
   assign w_drive = (r_scan_cnt != '0) & w_lit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scan_cnt    <= '0;
         r_idx         <= '0;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else begin
         r_scan_cnt  <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
         r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
         if (w_scan_wrap) begin
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
         end
         if (w_blink_wrap) begin
            r_blink_phase <= ~r_blink_phase;
         end
      end
   end

   // Inputs are sampled only at frame boundaries so a mid-scan update cannot tear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word_buf   <= '0;
         r_en_buf     <= '0;
         r_blink_buf  <= '0;
         r_dp_buf     <= '0;
         r_load_pend  <= 1'b1;
         r_frame_tick <= 1'b0;
      end else begin
         r_load_pend  <= 1'b0;
         r_frame_tick <= w_load;
         if (w_load) begin
            r_word_buf  <= display_in;
            r_en_buf    <= digit_en;
            r_blink_buf <= blink_en;
            r_dp_buf    <= dp_in;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_an  <= AN_OFF;
         r_seg <= SEG_OFF;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_drive ? ~(NUM_DIGITS'(1) << r_idx) : AN_OFF;
         r_seg <= w_drive ? ~w_seg_hi : SEG_OFF;
         r_dp  <= w_drive ? ~r_dp_buf[r_idx] : 1'b1;
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign dp         = r_dp;
   assign frame_tick = r_frame_tick;
endmodule

// File: tb/tb_ss_scan_driver.sv
// Directed bench for ss_scan_driver: an edge-count model predicts every pin each cycle,
// and literal checks at chosen edges pin the model to hand-decoded values.
module tb_ss_scan_driver;
   localparam int S = 4;
   localparam int B = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] display_in = 32'hFFFF_FFFF;
   logic [7:0]  digit_en = 8'hFF;
   logic [7:0]  blink_en = 8'h00;
   logic [7:0]  dp_in = 8'h00;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;
   int cur = -1;

   always #5 clk = ~clk;

   ss_scan_driver #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
      .clk        (clk),
      .rst        (rst),
      .display_in (display_in),
      .digit_en   (digit_en),
      .blink_en   (blink_en),
      .dp_in      (dp_in),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   logic [6:0] glyph [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   task automatic pins(input string name, input logic [7:0] e_a, input logic [6:0] e_s, input logic e_d);
      chk({name, ".an"}, an, e_a);
      chk({name, ".seg"}, seg, e_s);
      chk({name, ".dp"}, dp, e_d);
   endtask

   // Model: t counts edges since reset release; slot and blink phase follow by division.
   int          t = 0;
   logic [31:0] m_word = '0;
   logic [7:0]  m_en = '0, m_blink = '0, m_dp = '0;
   logic [7:0]  e_an = 8'hFF;
   logic [6:0]  e_seg = 7'h7F;
   logic        e_dp = 1'b1, e_tick = 1'b0;

   initial begin : model
      int  pos, slot;
      bit  dark, lit;
      forever begin
         @(posedge clk);
         if (rst) begin
            t = 0;
            m_word = '0; m_en = '0; m_blink = '0; m_dp = '0;
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
         end else begin
            pos  = t % S;
            slot = (t / S) % 8;
            dark = ((t / B) % 2) == 1;
            lit  = m_en[slot] && !(m_blink[slot] && dark);
            if (pos != 0 && lit) begin
               e_an  = ~(8'h01 << slot);
               e_seg = ~glyph[m_word[4*slot +: 4]];
               e_dp  = ~m_dp[slot];
            end else begin
               e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
            end
            e_tick = (t == 0) || ((t % (8*S)) == (8*S - 1));
            if (e_tick) begin
               m_word = display_in; m_en = digit_en; m_blink = blink_en; m_dp = dp_in;
            end
            t++;
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("cyc_an_rst", an, 8'hFF);
            chk("cyc_seg_rst", seg, 7'h7F);
            chk("cyc_dp_rst", dp, 1'b1);
            chk("cyc_tick_rst", frame_tick, 1'b0);
         end else begin
            chk("cyc_an", an, e_an);
            chk("cyc_seg", seg, e_seg);
            chk("cyc_dp", dp, e_dp);
            chk("cyc_tick", frame_tick, e_tick);
         end
      end
   end

   task automatic adv_to(input int e);
      repeat (e - cur) @(posedge clk);
      cur = e;
      #2;
   endtask

   initial begin : stim
      repeat (5) @(posedge clk);
      #2;
      pins("reset_hold", 8'hFF, 7'h7F, 1'b1);
      chk("reset_tick", frame_tick, 1'b0);
      rst = 1'b0;
      cur = -1;

      adv_to(0);   chk("first_load_tick", frame_tick, 1'b1); chk("first_load_an", an, 8'hFF);
      adv_to(1);   pins("first_digit_F", 8'hFE, 7'h0E, 1'b1); chk("tick_single", frame_tick, 1'b0);
      display_in = 32'h3100_1205;

      adv_to(33);  pins("slot0_5", 8'hFE, 7'h12, 1'b1);
      adv_to(37);  pins("slot1_0", 8'hFD, 7'h40, 1'b1);
      adv_to(41);  pins("slot2_2", 8'hFB, 7'h24, 1'b1);
      adv_to(61);  pins("slot7_3", 8'h7F, 7'h30, 1'b1);
      adv_to(63);  chk("frame_end_tick", frame_tick, 1'b1);

      adv_to(77);  pins("slot3_1", 8'hF7, 7'h79, 1'b1);
      display_in = 32'h8888_8888;
      adv_to(93);  pins("no_tear_slot7", 8'h7F, 7'h30, 1'b1);
      adv_to(95);  chk("tear_frame_tick", frame_tick, 1'b1);
      adv_to(97);  pins("new_word_8", 8'hFE, 7'h00, 1'b1);

      digit_en = 8'b1111_0111;
      dp_in    = 8'h01;
      adv_to(129); pins("dp_slot0", 8'hFE, 7'h00, 1'b0);
      adv_to(133); pins("dp_slot1_off", 8'hFD, 7'h00, 1'b1);
      adv_to(141); pins("masked_slot3", 8'hFF, 7'h7F, 1'b1);

      display_in = 32'hFEDC_BA98;
      digit_en   = 8'hFF;
      blink_en   = 8'h01;
      adv_to(161); pins("blink_vis_slot0", 8'hFE, 7'h00, 1'b0);
      adv_to(165); pins("slot1_9", 8'hFD, 7'h10, 1'b1);
      adv_to(193); pins("blink_dark_slot0", 8'hFF, 7'h7F, 1'b1);
      adv_to(197); pins("blink_other_lit", 8'hFD, 7'h10, 1'b1);
      adv_to(257); pins("blink_vis_again", 8'hFE, 7'h00, 1'b0);
      adv_to(309); pins("slot5_d", 8'hDF, 7'h21, 1'b1);

      #1 rst = 1'b1;
      #1 pins("async_off", 8'hFF, 7'h7F, 1'b1);
      display_in = 32'hA5A5_A5A5;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      cur = -1;
      adv_to(0);   chk("reload_tick", frame_tick, 1'b1); chk("reload_an", an, 8'hFF);
      adv_to(1);   pins("restart_slot0", 8'hFE, 7'h12, 1'b0);
      adv_to(5);   pins("restart_slot1_A", 8'hFD, 7'h08, 1'b1);
      adv_to(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
